// File: rtl/cp0_exc_unit_pkg.sv
// cp0_exc_unit_pkg
//   Shared constants for the CP0 exception unit:
//   - CP0 register numbers: SR, Cause, EPC, PRId, Count, Compare.
//   - Exception codes.
//   - SR/Cause bit-field positions.
//   - A small address-alignment helper.
//   No ports; imported by cp0_exc_unit and cp0_timer.
package cp0_exc_unit_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // SR fields
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;
  // Cause fields
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // EPC always holds a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// cp0_timer
//   Count/Compare timer for CP0.
//   - Count increments every cycle and wraps at 2^32.
//   - TI is a sticky flag that sets when Count equals a non-zero Compare.
//   - Writing Compare clears TI.
//   - Writing Count loads the written value.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     wr_count, wr_compare  accepted mtc0 write strobes
//     din                   mtc0 write data
//     count, compare        current register values
//     ti                    sticky timer interrupt flag
module cp0_timer
  import cp0_exc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      count <= wr_count ? din : count + 32'd1;
      if (wr_compare) begin
        compare <= din;
        ti      <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
//   Coprocessor-0 exception/interrupt unit.
//   - Arbitrates pipeline exceptions against level-sensitive hardware
//     interrupts; an interrupt beats an exception.
//   - Holds SR/Cause/EPC/PRId.
//   - Raises the flush/redirect request and serves mfc0/mtc0/eret.
//   Optional feature: define CP0_TIMER_EN to add Count(9)/Compare(11) and
//   a timer interrupt OR-ed onto IP[15].
//   Ports:
//     clk, reset     clock, asynchronous active-low reset
//     A1 / DOut      mfc0 register number / combinational read data
//     A2, DIn, We    mtc0 register number, data, enable
//     PC, BDIn       commit-stage PC and branch-delay-slot flag
//     ExcCodeIn      pending exception code (0 = none)
//     HWInt          external interrupt lines
//     EXLClr         eret at commit
//     IntReq         take exception/interrupt this cycle
//     HandlerPC      handler entry address
//     EPC            current EPC (eret target)
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4D49,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] HandlerPC,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic [5:0]  ip_next;
  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic        wr_ok;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Gating with reset keeps IntReq low while reset is held even if the
  // pipeline is presenting a fault code.
  assign int_pend = reset & (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend = reset & (ExcCodeIn != 5'd0) & ~sr_exl;
  assign int_req  = int_pend | exc_pend;
  assign IntReq   = int_req;

  // Taking an exception drops any same-cycle software write.
  assign wr_ok = We & ~int_req;

`ifdef CP0_TIMER_EN
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        timer_int;

  cp0_timer u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .wr_count   (wr_ok && (A2 == REG_COUNT)),
    .wr_compare (wr_ok && (A2 == REG_COMPARE)),
    .din        (DIn),
    .count      (count_val),
    .compare    (compare_val),
    .ti         (timer_int)
  );

  assign ip_next = {HWInt[5] | timer_int, HWInt[4:0]};
`else
  assign ip_next = HWInt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      cause_ip <= ip_next;
      if (int_req) begin
        // EXL set here also wins over a same-cycle eret.
        sr_exl    <= 1'b1;
        cause_exc <= int_pend ? EXC_INT : ExcCodeIn;
        cause_bd  <= BDIn;
        epc_q     <= word_align(BDIn ? (PC - 32'd4) : PC);
      end else begin
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
        if (wr_ok && (A2 == REG_SR)) begin
          sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
          sr_exl <= DIn[SR_EXL];
          sr_ie  <= DIn[SR_IE];
        end
        if (wr_ok && (A2 == REG_EPC)) begin
          epc_q <= word_align(DIn);
        end
      end
    end
  end

  always_comb begin
    sr_word = 32'd0;
    sr_word[SR_IM_HI:SR_IM_LO] = sr_im;
    sr_word[SR_EXL]            = sr_exl;
    sr_word[SR_IE]             = sr_ie;
  end

  always_comb begin
    cause_word = 32'd0;
    cause_word[CAUSE_BD]                  = cause_bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
  end

  // Read mux sees only registered state, so a same-cycle mtc0 is not
  // visible until the following cycle.
  always_comb begin
    DOut = 32'd0;
    if (reset) begin
      case (A1)
        REG_SR:      DOut = sr_word;
        REG_CAUSE:   DOut = cause_word;
        REG_EPC:     DOut = epc_q;
        REG_PRID:    DOut = PRID_VALUE;
`ifdef CP0_TIMER_EN
        REG_COUNT:   DOut = count_val;
        REG_COMPARE: DOut = compare_val;
`endif
        default:     DOut = 32'd0;
      endcase
    end
  end

  assign HandlerPC = EXC_VECTOR;
  assign EPC       = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  A1 = '0;
  logic [4:0]  A2 = '0;
  logic [31:0] DIn = '0;
  logic        We = 1'b0;
  logic [31:0] PC = '0;
  logic        BDIn = 1'b0;
  logic [4:0]  ExcCodeIn = '0;
  logic [5:0]  HWInt = '0;
  logic        EXLClr = 1'b0;
  logic        IntReq;
  logic [31:0] HandlerPC;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  cp0_exc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .We        (We),
    .PC        (PC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .IntReq    (IntReq),
    .HandlerPC (HandlerPC),
    .EPC       (EPC),
    .DOut      (DOut)
  );

  always #5 clk = ~clk;

  // Architectural model: whole 32-bit register words.
  logic [31:0] m_sr = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc = '0;
  logic [31:0] m_count = '0;
  logic [31:0] m_compare = '0;
  logic        m_ti = 1'b0;

  function automatic logic exp_int();
    return reset && ((m_cause[15:10] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic exp_req();
    return exp_int() || (reset && (ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] nxt_cause();
    logic [5:0] ip;
    ip = HWInt;
`ifdef CP0_TIMER_EN
    ip[5] = HWInt[5] | m_ti;
`endif
    if (exp_req())
      return {BDIn, 15'd0, ip, 3'd0, (exp_int() ? 5'd0 : ExcCodeIn), 2'd0};
    return {m_cause[31], 15'd0, ip, 3'd0, m_cause[6:2], 2'd0};
  endfunction

  function automatic logic [31:0] nxt_sr();
    if (exp_req()) return m_sr | 32'h2;
    if (We && A2 == 5'd12) return DIn & 32'h0000_FC03;
    if (EXLClr) return m_sr & ~32'h2;
    return m_sr;
  endfunction

  function automatic logic [31:0] nxt_epc();
    logic [31:0] v;
    if (exp_req()) begin
      v = BDIn ? PC - 32'd4 : PC;
      return v & ~32'h3;
    end
    if (We && A2 == 5'd14) return DIn & ~32'h3;
    return m_epc;
  endfunction

  function automatic logic [31:0] exp_dout();
    if (!reset) return 32'd0;
    case (A1)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0000_4D49;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sr <= '0; m_cause <= '0; m_epc <= '0;
      m_count <= '0; m_compare <= '0; m_ti <= 1'b0;
    end else begin
      m_sr    <= nxt_sr();
      m_cause <= nxt_cause();
      m_epc   <= nxt_epc();
      m_count <= (!exp_req() && We && A2 == 5'd9) ? DIn : m_count + 32'd1;
      if (!exp_req() && We && A2 == 5'd11) begin
        m_compare <= DIn;
        m_ti      <= 1'b0;
      end else if (m_count == m_compare && m_compare != 32'd0) begin
        m_ti <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("intreq", {31'd0, IntReq}, {31'd0, exp_req()});
      check("dout", DOut, exp_dout());
      check("epc", EPC, m_epc);
      check("handler", HandlerPC, 32'h0000_4180);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    We = 1'b1; A2 = r; DIn = d;
    tick();
    We = 1'b0; A2 = 5'd0; DIn = 32'd0;
  endtask

  task automatic read_chk(input string name, input logic [4:0] r, input logic [31:0] exp);
    A1 = r;
    #1;
    check(name, DOut, exp);
  endtask

  initial begin
    bit seen;
    #2 reset = 1'b0;
    HWInt = 6'h3F;
    ExcCodeIn = 5'd12;
    tick();
    chk_en = 1'b1;
    // Reset held: no request and reads are 0 for every register number.
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      tick();
      check("rst_dout", DOut, 32'd0);
      check("rst_intreq", {31'd0, IntReq}, 32'd0);
    end
    HWInt = 6'd0; ExcCodeIn = 5'd0;
    reset = 1'b1;
    read_chk("sr_after_reset", 5'd12, 32'd0);
    check("handler_lit", HandlerPC, 32'h0000_4180);
    read_chk("prid", 5'd15, 32'h0000_4D49);

    // Interrupt path: IP registers one edge after HWInt changes.
    mtc0(5'd12, 32'h0000_FC01);
    read_chk("sr_write", 5'd12, 32'h0000_FC01);
    PC = 32'h0000_2000;
    HWInt = 6'b000100;
    #1 check("int_not_yet", {31'd0, IntReq}, 32'd0);
    tick();
    check("int_asserted", {31'd0, IntReq}, 32'd1);
    tick();
    read_chk("int_cause", 5'd13, 32'h0000_1000);
    read_chk("int_sr_exl", 5'd12, 32'h0000_FC03);
    check("int_epc", EPC, 32'h0000_2000);

    // ALU overflow in a delay slot.
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    ExcCodeIn = 5'd12; PC = 32'h0000_3010; BDIn = 1'b1;
    #1 check("ov_req", {31'd0, IntReq}, 32'd1);
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    check("ov_epc", EPC, 32'h0000_300C);
    read_chk("ov_cause", 5'd13, 32'h8000_0030);

    // Interrupt beats exception; nested exception masked by EXL.
    HWInt = 6'b000001; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    ExcCodeIn = 5'd4; PC = 32'h0000_4000;
    tick();
    read_chk("prio_cause", 5'd13, 32'h0000_0400);
    ExcCodeIn = 5'd10; PC = 32'h0000_5000;
    #1 check("nested_masked", {31'd0, IntReq}, 32'd0);
    tick();
    ExcCodeIn = 5'd0;
    check("nested_epc", EPC, 32'h0000_4000);

    // eret re-exposes the pending interrupt; the take drops mtc0 and eret.
    EXLClr = 1'b1;
    tick();
    #1 check("reassert", {31'd0, IntReq}, 32'd1);
    We = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234; PC = 32'h0000_6004;
    tick();
    We = 1'b0; EXLClr = 1'b0;
    check("drop_mtc0_epc", EPC, 32'h0000_6004);
    read_chk("exl_kept", 5'd12, 32'h0000_FC03);

    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    We = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007;
    read_chk("no_bypass", 5'd14, 32'h0000_6004);
    tick();
    We = 1'b0;
    read_chk("epc_align", 5'd14, 32'h0000_3004);
    mtc0(5'd13, 32'hFFFF_FFFF);
    read_chk("cause_ro", 5'd13, 32'h0000_0000);
    mtc0(5'd12, 32'hFFFF_FFFF);
    read_chk("sr_mask", 5'd12, 32'h0000_FC03);
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'h0000_0077);
    read_chk("count_absent", 5'd9, 32'd0);
    read_chk("compare_absent", 5'd11, 32'd0);
`endif
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // Reset in the middle of a handler.
    ExcCodeIn = 5'd5; PC = 32'h0000_7000;
    tick();
    ExcCodeIn = 5'd0;
    check("pre_rst_epc", EPC, 32'h0000_7000);
    #1 reset = 1'b0;
    #1 check("midrst_epc", EPC, 32'd0);
    check("midrst_intreq", {31'd0, IntReq}, 32'd0);
    tick();
    reset = 1'b1;
    read_chk("midrst_sr", 5'd12, 32'd0);

`ifdef CP0_TIMER_EN
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (IntReq) seen = 1'b1;
      else tick();
    end
    check("timer_fired", {31'd0, seen}, 32'd1);
    read_chk("timer_ip", 5'd13, 32'h0000_8000);
    tick();
    mtc0(5'd11, 32'd0);
    tick();
    A1 = 5'd13;
    #1 check("ti_cleared", DOut & 32'h0000_8000, 32'd0);
`else
    seen = 1'b0;
    check("no_timer", {31'd0, seen}, {31'd0, IntReq});
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
